// File: rtl/output_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// output_mem_pkg
// Shared constants and types for the output memory controller.
//   ACCUM_ROW : words per accumulator bank (ACCUM_SIZE / SYS_COL)
//   CNT_W     : width of row/cycle counters; one bit wider than a bank address
//               so that a full ACCUM_ROW count and the skew tail fit
//   state_t   : controller FSM states
// ----------------------------------------------------------------------------
package output_mem_pkg;

    localparam int unsigned ACCUM_ROW = 256;
    localparam int unsigned CNT_W     = $clog2(ACCUM_ROW) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        READ
    } state_t;

endpackage

// File: rtl/output_mem_ctrl_accum_add.sv
// ----------------------------------------------------------------------------
// accum_add
// Per-column combine stage of the accumulator read-modify-write.
// Build option: ACC_SAT_EN -- when defined, accumulation saturates to the
// signed range; otherwise it wraps modulo 2^DATA_WIDTH.
// Ports:
//   accumulate : 1 = y = a + b, 0 = y = a (overwrite, never saturated)
//   a          : new result from the array
//   b          : current bank contents
//   y          : value to write back
// ----------------------------------------------------------------------------
module accum_add
    import output_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  accumulate,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    logic [DATA_WIDTH-1:0] sum;

    always_comb begin
        sum = a + b;
        y   = sum;
`ifdef ACC_SAT_EN
        // Signed overflow: operands share a sign that the sum does not.
        if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
            y = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
        if (!accumulate) begin
            y = a;
        end
    end

endmodule

// File: rtl/output_mem_ctrl.sv
// ----------------------------------------------------------------------------
// output_mem_ctrl
// Receive side of the systolic array: de-skews column results, read-modify-
// writes them into per-column accumulator banks (overwrite or accumulate),
// and later streams the banks out row-parallel.
// Build option: ACC_SAT_EN -- saturating accumulate (see accum_add).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   acc_start_in/accumulate_in: start capture of num_row rows, mode select
//   rd_start_in              : start row-parallel readout of num_row rows
//   num_row                  : row count, clamped to ACCUM_ROW, sampled at start
//   sys_out_data             : array bottom outputs, column j valid with acc_rd_en[j]
//   acc_rd_en/addr, acc_rd_data : per-bank read port (1-cycle read latency)
//   acc_wr_en/addr/data      : per-bank write port
//   out_rd_en/out_rd_addr    : readout enable (all bits equal) and shared address
//   out_valid                : bank readout data valid
//   busy, acc_done, rd_done  : status; done signals are 1-cycle pulses
// ----------------------------------------------------------------------------
module output_mem_ctrl
    import output_mem_pkg::*;
#(
    parameter int SYS_ROW    = 16,
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ACCUM_SIZE = 4096,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             acc_start_in,
    input  logic                             accumulate_in,
    input  logic                             rd_start_in,
    input  logic [DATA_WIDTH-1:0]            num_row,
    input  logic [SYS_COL*DATA_WIDTH-1:0]    sys_out_data,
    output logic [SYS_COL-1:0]               acc_rd_en,
    output logic [SYS_COL*ADDR_WIDTH-1:0]    acc_rd_addr,
    input  logic [SYS_COL*DATA_WIDTH-1:0]    acc_rd_data,
    output logic [SYS_COL-1:0]               acc_wr_en,
    output logic [SYS_COL*ADDR_WIDTH-1:0]    acc_wr_addr,
    output logic [SYS_COL*DATA_WIDTH-1:0]    acc_wr_data,
    output logic [SYS_COL-1:0]               out_rd_en,
    output logic [ADDR_WIDTH-1:0]            out_rd_addr,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             acc_done,
    output logic                             rd_done
);

    if ((ACCUM_SIZE / SYS_COL) != ACCUM_ROW || SYS_ROW < 1) begin : g_bad_cfg
        $error("output_mem_ctrl: ACCUM_SIZE/SYS_COL must equal ACCUM_ROW");
    end

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, n_q, n_in, acc_last;
    logic                   accum_q;
    logic                   start;

    logic                   acc_done_d, rd_done_d, busy_d, skew_in, out_en_d;

    logic [SYS_COL-1:0]     skew_q, wr_en_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q [SYS_COL];
    logic [ADDR_WIDTH-1:0]  wr_addr_q [SYS_COL];
    logic [DATA_WIDTH-1:0]  sys_q     [SYS_COL];
    logic [DATA_WIDTH-1:0]  sum_y     [SYS_COL];
    logic                   out_en_q, out_valid_q, busy_q, acc_done_q, rd_done_q;
    logic [ADDR_WIDTH-1:0]  out_addr_q;

    always_comb begin
        n_in = (32'(num_row) > ACCUM_ROW) ? CNT_W'(ACCUM_ROW) : CNT_W'(num_row);
        // Capture ends once the last column has written its last row.
        acc_last = (n_q == '0) ? '0 : n_q + CNT_W'(SYS_COL);
        start = (state_q == IDLE) && (acc_start_in || rd_start_in);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acc_start_in has priority over rd_start_in
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_start_in)     state_d = ACC;
                else if (rd_start_in) state_d = READ;
            end
            ACC:     if (cnt_q == acc_last) state_d = IDLE;
            READ:    if (cnt_q == n_q)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        acc_done_d = (state_q == ACC)  && (cnt_q == acc_last);
        rd_done_d  = (state_q == READ) && (cnt_q == n_q);
        busy_d     = (state_q != IDLE);
        skew_in    = (state_q == ACC)  && (cnt_q < n_q);
        out_en_d   = (state_q == READ) && (cnt_q < n_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            n_q         <= '0;
            accum_q     <= 1'b0;
            skew_q      <= '0;
            wr_en_q     <= '0;
            out_en_q    <= 1'b0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_done_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            for (int unsigned j = 0; j < SYS_COL; j++) begin
                rd_addr_q[j] <= '0;
                wr_addr_q[j] <= '0;
                sys_q[j]     <= '0;
            end
        end else begin
            if (start) begin
                cnt_q   <= '0;
                n_q     <= n_in;
                accum_q <= acc_start_in && accumulate_in;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Column j sees the row stream j cycles after column 0.
            skew_q      <= {skew_q[SYS_COL-2:0], skew_in};
            wr_en_q     <= skew_q;
            out_en_q    <= out_en_d;
            out_addr_q  <= out_en_d ? cnt_q[ADDR_WIDTH-1:0] : '0;
            out_valid_q <= out_en_q;
            busy_q      <= busy_d;
            acc_done_q  <= acc_done_d;
            rd_done_q   <= rd_done_d;

            for (int unsigned j = 0; j < SYS_COL; j++) begin
                if (start) begin
                    rd_addr_q[j] <= '0;
                end else if (skew_q[j]) begin
                    rd_addr_q[j] <= rd_addr_q[j] + ADDR_WIDTH'(1);
                end
                if (skew_q[j]) begin
                    sys_q[j]     <= sys_out_data[j*DATA_WIDTH +: DATA_WIDTH];
                    wr_addr_q[j] <= rd_addr_q[j];
                end
            end
        end
    end

    // The bank returns read data in the cycle after the read, which is the
    // write cycle, so the combine sits between registered operands and the
    // write port; it is forced to zero whenever no write is issued.
    for (genvar j = 0; j < SYS_COL; j++) begin : g_col
        accum_add #(.DATA_WIDTH(DATA_WIDTH)) u_add (
            .accumulate (accum_q),
            .a          (sys_q[j]),
            .b          (acc_rd_data[j*DATA_WIDTH +: DATA_WIDTH]),
            .y          (sum_y[j])
        );
        assign acc_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr_q[j];
        assign acc_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr_q[j];
        assign acc_wr_data[j*DATA_WIDTH +: DATA_WIDTH] = wr_en_q[j] ? sum_y[j] : '0;
    end

    assign acc_rd_en   = skew_q;
    assign acc_wr_en   = wr_en_q;
    assign out_rd_en   = {SYS_COL{out_en_q}};
    assign out_rd_addr = out_addr_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign acc_done    = acc_done_q;
    assign rd_done     = rd_done_q;

endmodule

// File: tb/tb_output_mem_ctrl.sv
module tb_output_mem_ctrl;

    localparam int SC = 16;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int AR = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_start_in, accumulate_in, rd_start_in;
    logic [DW-1:0]     num_row;
    logic [SC*DW-1:0]  sys_out_data;
    logic [SC-1:0]     acc_rd_en;
    logic [SC*AW-1:0]  acc_rd_addr;
    logic [SC*DW-1:0]  acc_rd_data;
    logic [SC-1:0]     acc_wr_en;
    logic [SC*AW-1:0]  acc_wr_addr;
    logic [SC*DW-1:0]  acc_wr_data;
    logic [SC-1:0]     out_rd_en;
    logic [AW-1:0]     out_rd_addr;
    logic              out_valid, busy, acc_done, rd_done;

    always #5 clk = ~clk;

    output_mem_ctrl #(
        .SYS_ROW    (16),
        .SYS_COL    (SC),
        .DATA_WIDTH (DW),
        .ACCUM_SIZE (4096),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .acc_start_in  (acc_start_in),
        .accumulate_in (accumulate_in),
        .rd_start_in   (rd_start_in),
        .num_row       (num_row),
        .sys_out_data  (sys_out_data),
        .acc_rd_en     (acc_rd_en),
        .acc_rd_addr   (acc_rd_addr),
        .acc_rd_data   (acc_rd_data),
        .acc_wr_en     (acc_wr_en),
        .acc_wr_addr   (acc_wr_addr),
        .acc_wr_data   (acc_wr_data),
        .out_rd_en     (out_rd_en),
        .out_rd_addr   (out_rd_addr),
        .out_valid     (out_valid),
        .busy          (busy),
        .acc_done      (acc_done),
        .rd_done       (rd_done)
    );

    // Accumulator banks: synchronous read, one cycle latency
    logic [DW-1:0] mem [SC][AR];
    logic          preload_req = 1'b0;
    logic [DW-1:0] preload_val = '0;

    always @(posedge clk) begin
        for (int j = 0; j < SC; j++) begin
            if (preload_req) begin
                for (int a = 0; a < AR; a++) mem[j][a] <= preload_val;
            end else if (acc_wr_en[j]) begin
                mem[j][acc_wr_addr[j*AW +: AW]] <= acc_wr_data[j*DW +: DW];
            end
            if (acc_rd_en[j]) acc_rd_data[j*DW +: DW] <= mem[j][acc_rd_addr[j*AW +: AW]];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [SC][AR];
    logic [DW-1:0] in_dat  [SC][AR];
    logic [DW-1:0] exp_new [SC][AR];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef ACC_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return 16'(s);
    endfunction

    task automatic preload(input logic [DW-1:0] v);
        @(negedge clk);
        preload_val = v;
        preload_req = 1'b1;
        @(posedge clk);
        #1 preload_req = 1'b0;
        for (int j = 0; j < SC; j++)
            for (int a = 0; a < AR; a++) ref_mem[j][a] = v;
    endtask

    task automatic fill_in(input bit constant, input logic [DW-1:0] v);
        for (int j = 0; j < SC; j++)
            for (int r = 0; r < AR; r++) in_dat[j][r] = constant ? v : 16'($urandom);
    endtask

    task automatic zero_check();
        chk("rst_acc_rd_en",   acc_rd_en, 0);
        chk("rst_acc_rd_addr", |acc_rd_addr, 0);
        chk("rst_acc_wr_en",   acc_wr_en, 0);
        chk("rst_acc_wr_addr", |acc_wr_addr, 0);
        chk("rst_acc_wr_data", |acc_wr_data, 0);
        chk("rst_out_rd_en",   out_rd_en, 0);
        chk("rst_out_rd_addr", out_rd_addr, 0);
        chk("rst_out_valid",   out_valid, 0);
        chk("rst_busy",        busy, 0);
        chk("rst_acc_done",    acc_done, 0);
        chk("rst_rd_done",     rd_done, 0);
    endtask

    task automatic run_acc(input int nr, input bit accum, input bit rd_too, input int rst_at);
        int n, d, r, errs;
        logic [SC-1:0] er, ew;
        n = (nr > AR) ? AR : nr;
        d = (n == 0) ? 1 : n + SC + 1;
        for (int j = 0; j < SC; j++)
            for (int rr = 0; rr < n; rr++)
                exp_new[j][rr] = accum ? ref_add(ref_mem[j][rr], in_dat[j][rr]) : in_dat[j][rr];

        @(negedge clk);
        acc_start_in  = 1'b1;
        accumulate_in = accum;
        rd_start_in   = rd_too;
        num_row       = 16'(nr);
        @(posedge clk);
        #1;
        acc_start_in  = 1'b0;
        rd_start_in   = 1'b0;
        accumulate_in = 1'($urandom);
        num_row       = 16'($urandom);

        for (int k = 1; k <= d + 1; k++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < SC; j++) begin
                r = k - 1 - j;
                sys_out_data[j*DW +: DW] = (r >= 0 && r < n) ? in_dat[j][r] : 16'($urandom);
            end
            rd_start_in  = (k < d) ? 1'($urandom) : 1'b0;
            acc_start_in = (k < d) ? 1'($urandom) : 1'b0;

            er = '0;
            ew = '0;
            for (int j = 0; j < SC; j++) begin
                er[j] = (k - 1 - j >= 0) && (k - 1 - j < n);
                ew[j] = (k - 2 - j >= 0) && (k - 2 - j < n);
            end
            chk("acc_rd_en", acc_rd_en, er);
            chk("acc_wr_en", acc_wr_en, ew);
            chk("acc_done",  acc_done, k == d);
            chk("acc_busy",  busy, k <= d);
            chk("acc_out_rd_en", out_rd_en, 0);
            chk("acc_out_valid", out_valid, 0);
            for (int j = 0; j < SC; j++) begin
                if (er[j]) chk("acc_rd_addr", acc_rd_addr[j*AW +: AW], k - 1 - j);
                if (ew[j]) begin
                    chk("acc_wr_addr", acc_wr_addr[j*AW +: AW], k - 2 - j);
                    chk("acc_wr_data", acc_wr_data[j*DW +: DW], exp_new[j][k-2-j]);
                end
            end

            if (k == rst_at) begin
                rst          = 1'b1;
                rd_start_in  = 1'b0;
                acc_start_in = 1'b0;
                #1 zero_check();
                repeat (2) @(posedge clk);
                #1 zero_check();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end

        for (int j = 0; j < SC; j++)
            for (int rr = 0; rr < n; rr++) ref_mem[j][rr] = exp_new[j][rr];
        errs = 0;
        for (int j = 0; j < SC; j++)
            for (int a = 0; a < AR; a++)
                if (mem[j][a] !== ref_mem[j][a]) errs++;
        chk("bank_contents", errs, 0);
    endtask

    task automatic run_read(input int nr);
        int n, d;
        n = (nr > AR) ? AR : nr;
        d = n + 1;
        @(negedge clk);
        rd_start_in = 1'b1;
        num_row     = 16'(nr);
        @(posedge clk);
        #1;
        rd_start_in = 1'b0;
        num_row     = 16'($urandom);
        for (int k = 1; k <= d + 1; k++) begin
            @(posedge clk);
            #1;
            acc_start_in = (k < d) ? 1'($urandom) : 1'b0;
            chk("rd_out_rd_en", out_rd_en, (k <= n) ? 32'hFFFF : 32'h0);
            if (k <= n) chk("rd_out_rd_addr", out_rd_addr, k - 1);
            chk("rd_out_valid", out_valid, (k >= 2) && (k <= n + 1));
            chk("rd_done",      rd_done, k == d);
            chk("rd_busy",      busy, k <= d);
            chk("rd_acc_rd_en", acc_rd_en, 0);
            chk("rd_acc_wr_en", acc_wr_en, 0);
            chk("rd_acc_done",  acc_done, 0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        acc_start_in  = 1'b0;
        accumulate_in = 1'b0;
        rd_start_in   = 1'b0;
        num_row       = '0;
        sys_out_data  = '0;
        repeat (3) @(posedge clk);
        #1 zero_check();
        @(negedge clk);
        rst = 1'b0;

        preload(16'd0);
        fill_in(1'b0, '0);
        run_acc(3, 1'b0, 1'b0, 0);

        preload(16'd100);
        fill_in(1'b1, 16'd5);
        run_acc(2, 1'b1, 1'b0, 0);
        chk("acc_once_105", mem[7][1], 16'd105);
        run_acc(2, 1'b1, 1'b0, 0);
        chk("acc_twice_110", mem[3][1], 16'd110);

        preload(16'h7FF0);
        fill_in(1'b1, 16'h0020);
        run_acc(1, 1'b1, 1'b0, 0);
`ifdef ACC_SAT_EN
        chk("pos_sat", mem[15][0], 16'h7FFF);
`else
        chk("pos_wrap", mem[15][0], 16'h8010);
`endif
        preload(16'h8010);
        fill_in(1'b1, 16'hFFE0);
        run_acc(1, 1'b1, 1'b0, 0);
`ifdef ACC_SAT_EN
        chk("neg_sat", mem[0][0], 16'h8000);
`else
        chk("neg_wrap", mem[0][0], 16'h7FF0);
`endif

        preload(16'd0);
        fill_in(1'b0, '0);
        run_acc(0, 1'b1, 1'b0, 0);
        run_acc(300, 1'b0, 1'b0, 0);

        run_read(4);
        run_read(0);
        run_read(300);

        fill_in(1'b0, '0);
        run_acc(20, 1'b0, 1'b0, 5);
        preload(16'd0);
        fill_in(1'b0, '0);
        run_acc(5, 1'b1, 1'b0, 0);
        fill_in(1'b0, '0);
        run_acc(6, 1'b1, 1'b1, 0);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                fill_in(1'b0, '0);
                run_acc(int'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), 0);
            end else begin
                run_read(int'($urandom_range(0, 40)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
